reorder_buffer: RTL and testbench

- In-order commit buffer that sits directly downstream of the renamer.
- Captures each renamed instruction's `{old_phys, new_phys}` pair at dispatch, tracks out-of-order completion by tag, and commits in program order.
- At commit it frees the superseded physical register through the renamer's single retire port (`retirein`/`retire_ena_in`).
- On flush it squashes uncommitted entries youngest-first, returning their newly claimed physical registers through the same port.

---
 rtl/reorder_buffer.sv | 152 +++++++++++++++
 tb/tb_reorder_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order commit buffer behind the renamer: frees superseded physical registers at commit
// and newly claimed ones on flush. Define ROB_BYPASS_EN to let a head completion commit in the same cycle.
module reorder_buffer #(
   parameter int DEPTH = 8,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             disp_valid,
   input  logic [7:0]       disp_wbs,
   output logic             disp_ready,
   output logic [TAG_W-1:0] disp_tag,
   input  logic             cmpl_valid,
   input  logic [TAG_W-1:0] cmpl_tag,
   input  logic             flush,
   output logic             retire_ena,
   output logic [3:0]       retire_phys,
   output logic             commit_valid,
   output logic [TAG_W:0]   count,
   output logic             empty
);

   typedef enum logic {RUN, SQUASH} state_t;

   state_t state, state_next;

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] done_q;
   logic [3:0]       old_q [DEPTH];
   logic [3:0]       new_q [DEPTH];
   logic [TAG_W:0]   head_q;
   logic [TAG_W:0]   tail_q;

   logic [TAG_W-1:0] head_idx;
   logic [TAG_W-1:0] tail_idx;
   logic [TAG_W-1:0] last_idx;
   logic             full;
   logic             disp_fire;
   logic             head_done;
   logic             commit_fire;
   logic             squash_fire;
   logic             cmpl_hit;

   assign head_idx = head_q[TAG_W-1:0];
   assign tail_idx = tail_q[TAG_W-1:0];
   assign last_idx = tail_idx - TAG_W'(1);

   assign count = tail_q - head_q;
   assign empty = (count == '0);
   assign full  = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

   assign disp_ready = !full && (state == RUN);
   assign disp_tag   = tail_idx;
   assign disp_fire  = disp_valid && disp_ready;

`ifdef ROB_BYPASS_EN
   assign head_done = done_q[head_idx] || (cmpl_valid && (cmpl_tag == head_idx));
`else
   assign head_done = done_q[head_idx];
`endif

   // A flush cycle never commits, so the squash sees every uncommitted entry.
   assign commit_fire = (state == RUN) && !flush && valid_q[head_idx] && head_done;
   assign squash_fire = (state == SQUASH) && (count != '0);
   assign cmpl_hit    = (state == RUN) && cmpl_valid && valid_q[cmpl_tag]
                        && !(disp_fire && (cmpl_tag == tail_idx));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN: begin
            if (flush && (count != '0)) begin
               state_next = SQUASH;
            end
         end
         SQUASH: begin
            if (count <= {{TAG_W{1'b0}}, 1'b1}) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      retire_ena   = 1'b0;
      retire_phys  = 4'd0;
      commit_valid = 1'b0;
      case (state)
         RUN: begin
            if (commit_fire) begin
               commit_valid = 1'b1;
               retire_ena   = (old_q[head_idx] != 4'd0);
               retire_phys  = old_q[head_idx];
            end
         end
         SQUASH: begin
            if (squash_fire) begin
               retire_ena  = (new_q[last_idx] != 4'd0);
               retire_phys = new_q[last_idx];
            end
         end
         default: ;
      endcase
   end

   // Later assignments win, so a commit clears done even if a completion hits the same slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         if (cmpl_hit) begin
            done_q[cmpl_tag] <= 1'b1;
         end
         if (disp_fire) begin
            valid_q[tail_idx] <= 1'b1;
            done_q[tail_idx]  <= 1'b0;
         end
         if (commit_fire) begin
            valid_q[head_idx] <= 1'b0;
            done_q[head_idx]  <= 1'b0;
            head_q            <= head_q + 1'b1;
         end
         if (squash_fire) begin
            valid_q[last_idx] <= 1'b0;
            done_q[last_idx]  <= 1'b0;
            tail_q            <= tail_q - 1'b1;
         end else if (disp_fire) begin
            tail_q <= tail_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (disp_fire) begin
         old_q[tail_idx] <= disp_wbs[7:4];
         new_q[tail_idx] <= disp_wbs[3:0];
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a cycle table for commit ordering plus
// hand sequences for full, flush, reset mid-squash and completion latency.
module tb_reorder_buffer;

   localparam int DEPTH = 8;
   localparam int TAG_W = 3;
`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             disp_valid;
   logic [7:0]       disp_wbs;
   logic             disp_ready;
   logic [TAG_W-1:0] disp_tag;
   logic             cmpl_valid;
   logic [TAG_W-1:0] cmpl_tag;
   logic             flush;
   logic             retire_ena;
   logic [3:0]       retire_phys;
   logic             commit_valid;
   logic [TAG_W:0]   count;
   logic             empty;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic       rst_n;
      logic       dv;
      logic [7:0] wbs;
      logic       cv;
      logic [2:0] ctag;
      logic       fl;
      logic       rdy;
      logic [2:0] tag;
      logic       rena;
      logic [3:0] rphys;
      logic       cmt;
      logic [3:0] cnt;
      logic       emp;
   } vec_t;

   vec_t vecs[$];

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .disp_valid   (disp_valid),
      .disp_wbs     (disp_wbs),
      .disp_ready   (disp_ready),
      .disp_tag     (disp_tag),
      .cmpl_valid   (cmpl_valid),
      .cmpl_tag     (cmpl_tag),
      .flush        (flush),
      .retire_ena   (retire_ena),
      .retire_phys  (retire_phys),
      .commit_valid (commit_valid),
      .count        (count),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic dv, input logic [7:0] wbs,
                               input logic cv, input logic [2:0] ct, input logic fl,
                               input logic rdy, input logic [2:0] tag, input logic rena,
                               input logic [3:0] rphys, input logic cmt,
                               input logic [3:0] cnt, input logic emp);
      vec_t v;
      v.rst_n = r;   v.dv = dv;     v.wbs = wbs; v.cv = cv;   v.ctag = ct; v.fl = fl;
      v.rdy = rdy;   v.tag = tag;   v.rena = rena; v.rphys = rphys;
      v.cmt = cmt;   v.cnt = cnt;   v.emp = emp;
      return v;
   endfunction

   task automatic checkSignal(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string lbl, input logic rdy, input logic [2:0] tag,
                              input logic rena, input logic [3:0] rphys, input logic cmt,
                              input logic [3:0] cnt, input logic emp);
      checkSignal({lbl, ".disp_ready"},   disp_ready,   rdy);
      checkSignal({lbl, ".disp_tag"},     disp_tag,     tag);
      checkSignal({lbl, ".retire_ena"},   retire_ena,   rena);
      checkSignal({lbl, ".retire_phys"},  retire_phys,  rphys);
      checkSignal({lbl, ".commit_valid"}, commit_valid, cmt);
      checkSignal({lbl, ".count"},        count,        cnt);
      checkSignal({lbl, ".empty"},        empty,        emp);
   endtask

   // Inputs change just after a rising edge; outputs are then read mid-cycle.
   task automatic applyStimulus(input logic r, input logic dv, input logic [7:0] wbs,
                                input logic cv, input logic [2:0] ct, input logic fl);
      rst_n      = r;
      disp_valid = dv;
      disp_wbs   = wbs;
      cmpl_valid = cv;
      cmpl_tag   = ct;
      flush      = fl;
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      tick();
   endtask

   task automatic dispatchThree();
      logic [7:0] w [3];
      w[0] = 8'h19; w[1] = 8'h2A; w[2] = 8'h3B;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, w[i], 1'b0, 3'd0, 1'b0);
         tick();
      end
   endtask

   initial begin
      logic [3:0] sq [3];
      logic [7:0] w;

      rst_n = 1'b0; disp_valid = 1'b0; disp_wbs = 8'h00;
      cmpl_valid = 1'b0; cmpl_tag = '0; flush = 1'b0;
      tick();
      tick();

      // Single instruction, then four with out-of-order completion, then a no-destination one.
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,0,0,4'h0,0,0,1));
      vecs.push_back(mk(1,1,8'h38,0,0,0, 1,0,0,4'h0,0,0,1));
`ifdef ROB_BYPASS_EN
      vecs.push_back(mk(1,0,8'h00,1,0,0, 1,1,1,4'h3,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,1,0,4'h0,0,0,1));
`else
      vecs.push_back(mk(1,0,8'h00,1,0,0, 1,1,0,4'h0,0,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,1,1,4'h3,1,1,0));
`endif
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,1,0,4'h0,0,0,1));
      vecs.push_back(mk(0,0,8'h00,0,0,0, 1,1,0,4'h0,0,0,1));
      vecs.push_back(mk(1,1,8'h41,0,0,0, 1,0,0,4'h0,0,0,1));
      vecs.push_back(mk(1,1,8'h52,0,0,0, 1,1,0,4'h0,0,1,0));
      vecs.push_back(mk(1,1,8'h63,0,0,0, 1,2,0,4'h0,0,2,0));
      vecs.push_back(mk(1,1,8'h74,0,0,0, 1,3,0,4'h0,0,3,0));
      vecs.push_back(mk(1,0,8'h00,1,3,0, 1,4,0,4'h0,0,4,0));
      vecs.push_back(mk(1,0,8'h00,1,1,0, 1,4,0,4'h0,0,4,0));
`ifdef ROB_BYPASS_EN
      vecs.push_back(mk(1,0,8'h00,1,0,0, 1,4,1,4'h4,1,4,0));
      vecs.push_back(mk(1,0,8'h00,1,2,0, 1,4,1,4'h5,1,3,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,1,4'h6,1,2,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,1,4'h7,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,0,4'h0,0,0,1));
`else
      vecs.push_back(mk(1,0,8'h00,1,0,0, 1,4,0,4'h0,0,4,0));
      vecs.push_back(mk(1,0,8'h00,1,2,0, 1,4,1,4'h4,1,4,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,1,4'h5,1,3,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,1,4'h6,1,2,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,1,4'h7,1,1,0));
`endif
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,4,0,4'h0,0,0,1));
      vecs.push_back(mk(1,1,8'h00,0,0,0, 1,4,0,4'h0,0,0,1));
`ifdef ROB_BYPASS_EN
      vecs.push_back(mk(1,0,8'h00,1,4,0, 1,5,0,4'h0,1,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,5,0,4'h0,0,0,1));
`else
      vecs.push_back(mk(1,0,8'h00,1,4,0, 1,5,0,4'h0,0,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,5,0,4'h0,1,1,0));
`endif
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,5,0,4'h0,0,0,1));
      // Completion to an empty slot, then a completion racing its own dispatch: neither may mark done.
      vecs.push_back(mk(1,0,8'h00,1,5,0, 1,5,0,4'h0,0,0,1));
      vecs.push_back(mk(1,1,8'h9E,1,5,0, 1,5,0,4'h0,0,0,1));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,6,0,4'h0,0,1,0));
      vecs.push_back(mk(1,0,8'h00,0,0,0, 1,6,0,4'h0,0,1,0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst_n, vecs[i].dv, vecs[i].wbs, vecs[i].cv, vecs[i].ctag, vecs[i].fl);
         checkOutput($sformatf("row%0d", i), vecs[i].rdy, vecs[i].tag, vecs[i].rena,
                     vecs[i].rphys, vecs[i].cmt, vecs[i].cnt, vecs[i].emp);
         tick();
      end

      // Fill, then show a same-cycle commit does not reopen dispatch.
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         w = {4'(i + 1), 4'(i + 8)};
         applyStimulus(1'b1, 1'b1, w, 1'b0, 3'd0, 1'b0);
         checkSignal($sformatf("fill%0d.tag", i), disp_tag, 8'(i));
         tick();
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkSignal("full.disp_ready", disp_ready, 8'd0);
      checkSignal("full.count", count, 8'd8);
      checkSignal("full.disp_tag", disp_tag, 8'd0);
      tick();
`ifndef ROB_BYPASS_EN
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
      checkSignal("full.cmpl_commit_valid", commit_valid, 8'd0);
      tick();
`endif
      applyStimulus(1'b1, 1'b1, 8'hC5, BYP, 3'd0, 1'b0);
      checkSignal("full.commit_ready", disp_ready, 8'd0);
      checkSignal("full.commit_valid", commit_valid, 8'd1);
      checkSignal("full.retire_phys", retire_phys, 8'd1);
      checkSignal("full.commit_count", count, 8'd8);
      tick();
      applyStimulus(1'b1, 1'b1, 8'hC5, 1'b0, 3'd0, 1'b0);
      checkSignal("wrap.disp_ready", disp_ready, 8'd1);
      checkSignal("wrap.disp_tag", disp_tag, 8'd0);
      checkSignal("wrap.count", count, 8'd7);
      tick();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkSignal("refill.count", count, 8'd8);
      checkSignal("refill.disp_ready", disp_ready, 8'd0);
      checkSignal("refill.disp_tag", disp_tag, 8'd1);
      tick();

      // Flush squashes youngest-first, returning new_phys.
      sq[0] = 4'hB; sq[1] = 4'hA; sq[2] = 4'h9;
      doReset();
      dispatchThree();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
      checkSignal("flush.count", count, 8'd3);
      checkSignal("flush.commit_valid", commit_valid, 8'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
         checkSignal($sformatf("squash%0d.retire_ena", k), retire_ena, 8'd1);
         checkSignal($sformatf("squash%0d.retire_phys", k), retire_phys, 8'(sq[k]));
         checkSignal($sformatf("squash%0d.disp_ready", k), disp_ready, 8'd0);
         checkSignal($sformatf("squash%0d.count", k), count, 8'(3 - k));
         tick();
      end
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkOutput("postsquash", 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
      tick();

      // Reset lands in the middle of a squash.
      dispatchThree();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkSignal("midsq0.retire_phys", retire_phys, 8'h0B);
      tick();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkSignal("midsq1.retire_phys", retire_phys, 8'h0A);
      tick();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkOutput("rstmid", 1'b1, 3'd0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
      tick();

      // Completion-to-retire latency.
      applyStimulus(1'b1, 1'b1, 8'h5D, 1'b0, 3'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0);
      checkSignal("lat.same_retire_ena", retire_ena, 8'(BYP));
      checkSignal("lat.same_retire_phys", retire_phys, BYP ? 8'd5 : 8'd0);
      tick();
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0);
      checkSignal("lat.next_retire_ena", retire_ena, 8'(!BYP));
      checkSignal("lat.next_retire_phys", retire_phys, BYP ? 8'd0 : 8'd5);
      tick();

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
